sync_fifo: RTL
==============

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data word width in bits (1..256).
REQ-002 SHALL have parameter DEPTH, default 4, meaning entry count; power of two, 2..1024.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-1, meaning occupancy at or above which almost_full asserts (1..DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_valid  input  1  write request.
REQ-007 SHALL have port wr_data  input  WIDTH  write word.
REQ-008 SHALL have port wr_ready  output  1  FIFO can accept a word (not full).
REQ-009 SHALL have port rd_ready  input  1  consumer accepts head word.
REQ-010 SHALL have port rd_valid  output  1  head word present (not empty).
REQ-011 SHALL have port rd_data  output  WIDTH  head word, first-word-fall-through.
REQ-012 SHALL have, only when SYNC_FIFO_LEVEL_EN is defined, port level  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have, only when SYNC_FIFO_LEVEL_EN is defined, port almost_full  output  1  level >= AFULL_LEVEL.

Function
REQ-014 SHALL store words in a DEPTH-entry register array, indexed by wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits (extra wrap bit).
REQ-015 SHALL accept a write in a cycle iff wr_valid & wr_ready; the word goes to mem[wr_ptr] and wr_ptr increments.
REQ-016 SHALL complete a read in a cycle iff rd_valid & rd_ready; rd_ptr increments.
REQ-017 SHALL drive rd_valid = (wr_ptr != rd_ptr) and wr_ready = ~(index bits equal & wrap bits differ), both from registers only.
REQ-018 SHALL drive rd_data = mem[rd_ptr index], valid whenever rd_valid=1; value undefined-but-stable when empty.
REQ-019 SHALL present a word written in cycle N on rd_valid/rd_data in cycle N+1 (latency 1, no same-cycle bypass when empty).
REQ-020 SHALL, when full, keep wr_ready=0 even if a read occurs in the same cycle; wr_ready rises the cycle after the read.
REQ-021 SHALL, when neither empty nor full, allow simultaneous read and write, occupancy unchanged.
REQ-022 SHALL wrap pointers modulo 2*DEPTH with no lost or duplicated words across wrap.
REQ-023 SHALL ignore wr_data when write not accepted, and hold rd_data/rd_valid stable while rd_valid & ~rd_ready.
REQ-024 SHALL make wr_ready independent of wr_valid and rd_valid independent of rd_ready (no combinational input-to-output paths).

Reset
REQ-025 SHALL, while rst_n=0, immediately force wr_ptr=rd_ptr=0, so rd_valid=0, wr_ready=1, level=0, almost_full=0 (AFULL_LEVEL>0).
REQ-026 SHALL not reset the storage array; contents are discarded by pointer reset.
REQ-027 SHALL, on reset mid-transfer, drop all stored words; first post-release write behaves as into an empty FIFO.
REQ-028 SHALL release reset synchronously to clk (deassertion assumed synchronized upstream).

Configuration
REQ-029 SHALL, when SYNC_FIFO_LEVEL_EN is defined, maintain a registered occupancy counter: +1 write-only, -1 read-only, unchanged on both or neither; almost_full registered from next level.
REQ-030 SHALL, without SYNC_FIFO_LEVEL_EN, omit level, almost_full and the counter entirely; all other behaviour identical.

Verification
REQ-031 SHALL cover: DEPTH=4, reset, write 0x1111 in cycle 0 -> rd_valid=1, rd_data=0x1111 in cycle 1, not cycle 0.
REQ-032 SHALL cover: write 0xA0..0xA3 with rd_ready=0 -> wr_ready=0 after 4th, level=4, almost_full=1 from level 3; 5th wr_valid not accepted.
REQ-033 SHALL cover: full FIFO, rd_ready=1 and wr_valid=1 same cycle -> read 0xA0 completes, write rejected, wr_ready=1 next cycle, level=3.
REQ-034 SHALL cover: 1000 cycles random valid/ready, 10 full wraps -> output sequence equals input sequence, no loss or duplication.
REQ-035 SHALL cover: 2 words stored, rst_n pulsed low mid-cycle -> rd_valid=0, wr_ready=1 asynchronously; no old data emerges after release.
REQ-036 SHALL cover: build without SYNC_FIFO_LEVEL_EN -> elaborates without level/almost_full ports; scenarios 031-034 pass.

Source files
------------

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo
// ----------------------------------------------------------------------------
// Single-clock first-word-fall-through FIFO built on a register array.
//
// The head word is always visible on rd_data whenever rd_valid is high. A word
// written in one cycle appears at the output the following cycle. No bypass
// path exists from wr_data to rd_data, even when the FIFO is empty.
//
// Pointers are $clog2(DEPTH)+1 bits wide. The extra MSB is a wrap bit, so
// equal pointers mean empty. Equal index bits with differing wrap bits mean
// full. Both flags come straight from the pointer registers. As a result,
// wr_ready and rd_valid have no combinational dependence on any input.
//
// Optional feature macro: SYNC_FIFO_LEVEL_EN
//   When defined, the module adds the level and almost_full outputs. These
//   are driven by a registered occupancy counter. When undefined, the
//   counter and both ports are absent. All other behaviour is unchanged.
//
// Parameters
//   WIDTH       data word width in bits (1..256)
//   DEPTH       number of entries, power of two (2..1024)
//   AFULL_LEVEL occupancy at or above which almost_full asserts (1..DEPTH)
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset; releases synchronously
//   wr_valid    write request
//   wr_data     write word, ignored unless the write is accepted
//   wr_ready    FIFO can accept a word (not full)
//   rd_ready    consumer accepts the head word
//   rd_valid    head word present (not empty)
//   rd_data     head word (first-word-fall-through)
//   level       current occupancy            (SYNC_FIFO_LEVEL_EN only)
//   almost_full level >= AFULL_LEVEL         (SYNC_FIFO_LEVEL_EN only)
// ============================================================================
module sync_fifo #(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 4,
   parameter int AFULL_LEVEL = DEPTH - 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_valid,
   input  logic [WIDTH-1:0]           wr_data,
   output logic                       wr_ready,
   input  logic                       rd_ready,
   output logic                       rd_valid,
`ifdef SYNC_FIFO_LEVEL_EN
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       almost_full
`else
   output logic [WIDTH-1:0]           rd_data
`endif
);

   // Index width addresses the array; pointer width adds the wrap bit.
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   // Reject illegal parameter combinations at elaboration time rather than
   // letting a non-power-of-two depth silently corrupt the wrap arithmetic.
   if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
      $error("sync_fifo: WIDTH must be in 1..256");
   end
   if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two in 2..1024");
   end
   if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
      $error("sync_fifo: AFULL_LEVEL must be in 1..DEPTH");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             wr_fire;
   logic             rd_fire;
   logic             is_empty;
   logic             is_full;

   // Status flags come from the pointer registers only. A read in the same
   // cycle as a full condition therefore cannot open wr_ready until the next
   // cycle. This keeps every input-to-output path registered.
   always_comb begin
      is_empty = (wr_ptr == rd_ptr);
      is_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                 (wr_ptr[AW] != rd_ptr[AW]);
   end

   assign wr_ready = ~is_full;
   assign rd_valid = ~is_empty;
   assign wr_fire  = wr_valid & wr_ready;
   assign rd_fire  = rd_valid & rd_ready;

   // Head word is read straight out of the array. When the FIFO is empty the
   // value is stale but does not change, since nothing moves rd_ptr.
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Storage is deliberately left out of reset. Pointer reset is enough to
   // discard contents, and skipping the array reset keeps fanout small.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   // Pointers advance modulo 2*DEPTH through natural overflow of the extra
   // wrap bit. Reset clears both immediately, which empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_fire) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

`ifdef SYNC_FIFO_LEVEL_EN
   logic [PW-1:0] level_q;
   logic [PW-1:0] level_next;
   logic          almost_full_q;

   // Next occupancy. A simultaneous read and write cancel out, so only the
   // one-sided cases move the count.
   always_comb begin
      level_next = level_q;
      case ({wr_fire, rd_fire})
         2'b10:   level_next = level_q + PTR_ONE;
         2'b01:   level_next = level_q - PTR_ONE;
         default: level_next = level_q;
      endcase
   end

   // almost_full is registered from the next occupancy. It therefore tracks
   // level exactly on the same cycle, without a combinational compare on
   // the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q       <= '0;
         almost_full_q <= 1'b0;
      end else begin
         level_q       <= level_next;
         almost_full_q <= (level_next >= PW'(AFULL_LEVEL));
      end
   end

   assign level       = level_q;
   assign almost_full = almost_full_q;
`endif

endmodule
